handshake_skid: RTL and testbench
=================================

HANDSHAKE_SKID -- requirements
Module: handshake_skid

Interface
REQ-001 Parameter: WIDTH, default 8, payload width in bits.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 i_clear  input  1  synchronous discard of all held entries.
REQ-005 i_value  input  WIDTH  upstream payload.
REQ-006 i_valid  input  1  upstream payload valid.
REQ-007 o_ready  output  1  upstream may transfer; driven directly from a flop.
REQ-008 o_value  output  WIDTH  downstream payload; driven directly from a flop.
REQ-009 o_valid  output  1  downstream payload valid; driven directly from a flop.
REQ-010 i_ready  input  1  downstream accepts.
REQ-011 o_count  output  2  entries held (0..2); driven directly from a flop.

Function
REQ-012 The block SHALL register the ready path: o_ready SHALL have no combinational dependence on i_ready, i_valid or i_clear.
REQ-013 Input transfer ("in") SHALL occur when i_valid & o_ready; output transfer ("out") SHALL occur when o_valid & i_ready.
REQ-014 Storage SHALL be one output register (o_value) plus one skid register of WIDTH bits.
REQ-015 The state machine SHALL have states EMPTY (count 0, o_valid 0, o_ready 1), BUSY (count 1, o_valid 1, o_ready 1), FULL (count 2, o_valid 1, o_ready 0).
REQ-016 EMPTY: in -> BUSY with o_value <= i_value; otherwise stay.
REQ-017 BUSY: in & out -> BUSY with o_value <= i_value.
REQ-018 BUSY: in & !out -> FULL with skid <= i_value; o_value unchanged.
REQ-019 BUSY: !in & out -> EMPTY; o_value holds its last value.
REQ-020 BUSY: !in & !out -> stay BUSY with all registers unchanged.
REQ-021 FULL: out -> BUSY with o_value <= skid; otherwise stay FULL.
REQ-022 FULL: i_valid SHALL be ignored, because o_ready is 0.
REQ-023 Latency from an input transfer to o_valid SHALL be exactly 1 cycle when the block is EMPTY.
REQ-024 Sustained throughput SHALL be 1 transfer per cycle while i_ready stays 1.
REQ-025 Payload order SHALL be preserved, with no loss and no duplication.
REQ-026 o_value and o_valid SHALL hold stable while o_valid & !i_ready.
REQ-027 i_clear SHALL force EMPTY on the next edge, overriding any simultaneous in or out.
REQ-028 Data presented with i_clear SHALL be discarded, and o_value SHALL hold.
REQ-029 o_count SHALL always equal the state encoding (0/1/2) and SHALL change in the same cycle as the state.

Reset
REQ-030 On reset_n low the block SHALL asynchronously enter EMPTY: o_valid 0, o_ready 1, o_count 0, o_value 0, skid 0.
REQ-031 Reset asserted mid-operation (BUSY or FULL) SHALL discard held entries immediately, without waiting for a clock edge.
REQ-032 After reset_n rises, the first in SHALL be accepted on the first rising edge at which i_valid is 1.

Verification
REQ-033 Streaming: send 0x01..0x10 with i_valid=1 and i_ready=1 -> 16 outputs 0x01..0x10 on consecutive cycles, o_count stays 1, o_ready stays 1.
REQ-034 Backpressure: send 0xA1, 0xA2 with i_ready=0 -> o_count=2, o_ready=0, o_value=0xA1 held; raise i_ready -> 0xA1 then 0xA2 output, then o_count=0.
REQ-035 Input while FULL: hold i_valid=1 with 0xB3 while FULL -> 0xB3 is accepted only on the edge after o_ready returns to 1, and is output after 0xA2.
REQ-036 Clear: FULL with 0xC1/0xC2 held, assert i_clear together with i_valid=1 (0xC3) -> next cycle EMPTY, o_valid=0, o_count=0, and 0xC1, 0xC2 and 0xC3 never appear.
REQ-037 Async reset: drop reset_n mid-cycle while FULL -> o_valid=0, o_ready=1, o_count=0, o_value=0 before the next edge.
REQ-038 Random: random i_valid and i_ready at 50% each for 10000 cycles -> scoreboard shows in-order, lossless delivery, and a checker shows o_ready never depends on same-cycle i_ready.

Source files
------------

// File: rtl/handshake_skid_if.sv
// Valid/ready handshake bundle for the skid buffer.
// The slave side is the buffer itself; the master side drives the upstream
// payload and the downstream ready, and observes the buffer outputs.
interface handshake_skid_if #(
  parameter int WIDTH = 8
);
  logic             i_clear;
  logic [WIDTH-1:0] i_value;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_value;
  logic             o_valid;
  logic             i_ready;
  logic [1:0]       o_count;

  modport master (
    output i_clear, i_value, i_valid, i_ready,
    input  o_ready, o_value, o_valid, o_count
  );

  modport slave (
    input  i_clear, i_value, i_valid, i_ready,
    output o_ready, o_value, o_valid, o_count
  );
endinterface

// File: rtl/handshake_skid.sv
// Two-entry skid buffer that registers both the forward (valid/data) and
// the backward (ready) path of a valid/ready handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// EMPTY | nothing held; o_valid 0, o_ready 1, count 0
// BUSY  | one entry in the output register; o_valid 1, o_ready 1, count 1
// FULL  | output register plus skid register held; o_valid 1, o_ready 0
//
// Every output is a flop, so o_ready never sees same-cycle i_ready.
module handshake_skid #(
  parameter int WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  handshake_skid_if.slave      bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] skid_q,  skid_d;

  logic xfer_in;
  logic xfer_out;

  assign xfer_in  = bus.i_valid & ready_q;
  assign xfer_out = valid_q & bus.i_ready;

  // Next state and data-register updates; clear wins over any transfer and
  // leaves o_value untouched so downstream sees a stable (invalid) bus.
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    skid_d  = skid_q;

    case (state_q)
      EMPTY: begin
        if (xfer_in) begin
          state_d = BUSY;
          value_d = bus.i_value;
        end
      end
      BUSY: begin
        if (xfer_in && xfer_out) begin
          value_d = bus.i_value;
        end else if (xfer_in) begin
          state_d = FULL;
          skid_d  = bus.i_value;
        end else if (xfer_out) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // o_ready is low here, so i_valid cannot produce an input transfer.
        if (xfer_out) begin
          state_d = BUSY;
          value_d = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    if (bus.i_clear) begin
      state_d = EMPTY;
      value_d = value_q;
      skid_d  = skid_q;
    end

    ready_d = (state_d != FULL);
    valid_d = (state_d != EMPTY);
  end

  // State and output registers; reset empties the buffer immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      value_q <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      value_q <= value_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_value = value_q;
  assign bus.o_count = state_q;

endmodule

// File: tb/tb_handshake_skid.sv
// Self-checking bench for handshake_skid: directed vector table, streaming,
// async reset, and a randomized run against a queue-based reference model.
module tb_handshake_skid;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  handshake_skid_if #(.WIDTH(8)) bus ();

  handshake_skid #(.WIDTH(8)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit         clr;
    bit         vld;
    logic [7:0] val;
    bit         rdy;
    bit         e_valid;
    bit         e_ready;
    int         e_count;
    logic [7:0] e_value;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit c, input bit v, input logic [7:0] d, input bit r);
    bus.i_clear = c;
    bus.i_valid = v;
    bus.i_value = d;
    bus.i_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input bit v, input bit rd, input int cnt,
                           input logic [7:0] val);
    chk({tag, ".o_valid"}, 32'(bus.o_valid), 32'(v));
    chk({tag, ".o_ready"}, 32'(bus.o_ready), 32'(rd));
    chk({tag, ".o_count"}, 32'(bus.o_count), 32'(cnt));
    chk({tag, ".o_value"}, 32'(bus.o_value), 32'(val));
  endtask

  // Reference model: a plain FIFO of at most two entries plus the last value shown.
  logic [7:0] mq[$];
  logic [7:0] mval;

  initial begin
    drive(0, 0, 8'h00, 0);

    // Backpressure, input while FULL, then clear while FULL.
    vecs.push_back('{0, 1, 8'hA1, 0, 1, 1, 1, 8'hA1});
    vecs.push_back('{0, 1, 8'hA2, 0, 1, 0, 2, 8'hA1});
    vecs.push_back('{0, 1, 8'hB3, 0, 1, 0, 2, 8'hA1});
    vecs.push_back('{0, 1, 8'hB3, 1, 1, 1, 1, 8'hA2});
    vecs.push_back('{0, 1, 8'hB3, 1, 1, 1, 1, 8'hB3});
    vecs.push_back('{0, 0, 8'h00, 1, 0, 1, 0, 8'hB3});
    vecs.push_back('{0, 1, 8'hC1, 0, 1, 1, 1, 8'hC1});
    vecs.push_back('{0, 1, 8'hC2, 0, 1, 0, 2, 8'hC1});
    vecs.push_back('{1, 1, 8'hC3, 1, 0, 1, 0, 8'hC1});
    vecs.push_back('{0, 0, 8'h00, 1, 0, 1, 0, 8'hC1});
    vecs.push_back('{0, 0, 8'h00, 1, 0, 1, 0, 8'hC1});

    #12;
    check_out("reset", 0, 1, 0, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].vld, vecs[i].val, vecs[i].rdy);
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_ready,
                vecs[i].e_count, vecs[i].e_value);
    end

    // Streaming at full rate: one output per cycle, count pinned at 1.
    for (int k = 1; k <= 16; k++) begin
      drive(0, 1, 8'(k), 1);
      tick();
      check_out($sformatf("stream%0d", k), 1, 1, 1, 8'(k));
    end
    drive(0, 0, 8'h00, 1);
    tick();
    check_out("stream_drain", 0, 1, 0, 8'h10);

    // Async reset while FULL: outputs clear before any further edge.
    drive(0, 1, 8'hD1, 0);
    tick();
    drive(0, 1, 8'hD2, 0);
    tick();
    check_out("pre_reset_full", 1, 0, 2, 8'hD1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 0, 1, 0, 8'h00);
    drive(0, 0, 8'h00, 0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 8'hE1, 0);
    tick();
    check_out("first_after_reset", 1, 1, 1, 8'hE1);

    // Return to a known empty state for the random run.
    rst_n = 1'b0;
    #1;
    drive(0, 0, 8'h00, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    mq.delete();
    mval = 8'h00;

    for (int n = 0; n < 10000; n++) begin
      bit         c, v, r, rd0;
      logic [7:0] d;
      bit         t_in, t_out;
      c = ($urandom_range(0, 49) == 0);
      v = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 1) == 1;
      d = 8'($urandom);
      drive(c, v, d, r);
      #1;
      rd0 = bus.o_ready;
      drive(~c, ~v, ~d, ~r);
      #1;
      chk("ready_indep", 32'(bus.o_ready), 32'(rd0));
      drive(c, v, d, r);

      t_in  = v && (mq.size() < 2);
      t_out = (mq.size() > 0) && r;
      if (t_out) void'(mq.pop_front());
      if (t_in) mq.push_back(d);
      if (c) mq.delete();
      if (mq.size() > 0) mval = mq[0];

      tick();
      check_out("random", mq.size() > 0, mq.size() < 2, mq.size(), mval);
    end

    // Drain whatever the model still holds, in order.
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 8'h00, 1);
      if (mq.size() > 0) void'(mq.pop_front());
      if (mq.size() > 0) mval = mq[0];
      tick();
      check_out("final_drain", mq.size() > 0, mq.size() < 2, mq.size(), mval);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
